// File: rtl/tcs_pulse_emulator.sv
// tcs_pulse_emulator: colour-sensor light-to-frequency stand-in driving a 50% duty square wave per selected filter.
// Optional TCS_SCALE_EN adds s0/s1 frequency scaling (x50/x5/x1) and power-down.
module tcs_pulse_emulator #(
  parameter int PERIOD_W = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s2,
  input  logic                s3,
  input  logic [PERIOD_W-1:0] red_half,
  input  logic [PERIOD_W-1:0] blue_half,
  input  logic [PERIOD_W-1:0] clear_half,
  input  logic [PERIOD_W-1:0] green_half,
  output logic                pulse,
  output logic                active
`ifdef TCS_SCALE_EN
  ,
  input  logic                s0,
  input  logic                s1
`endif
);
`ifdef TCS_SCALE_EN
  localparam int CW = PERIOD_W + 6;
  localparam int SELW = 4;
`else
  localparam int CW = PERIOD_W;
  localparam int SELW = 2;
`endif
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {SETTLE, RUN_HIGH, RUN_LOW} state_t;
  state_t state, state_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic [CW-1:0] half_cnt, half_nx, h;
  logic [SYNC_STAGES-1:0][SELW-1:0] sync;
  logic [SELW-1:0] sel, raw;
  logic [PERIOD_W-1:0] base;
  logic changed, powerdown;
`ifdef TCS_SCALE_EN
  logic [5:0] mult;
  assign raw = {s0, s1, s2, s3};
  assign mult = sel[3:2] == 2'b01 ? 6'd50 : sel[3:2] == 2'b10 ? 6'd5 : sel[3:2] == 2'b11 ? 6'd1 : 6'd0;
  assign h = CW'(base) * CW'(mult);
  assign powerdown = sel[3:2] == 2'b00;
`else
  assign raw = {s2, s3};
  assign h = base;
  assign powerdown = 1'b0;
`endif
  assign changed = sync[SYNC_STAGES-1] != sel;
  assign base = sel[1:0] == 2'b00 ? red_half : sel[1:0] == 2'b01 ? blue_half :
                sel[1:0] == 2'b10 ? clear_half : green_half;
  assign pulse = state == RUN_HIGH;
  assign active = state != SETTLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      sel <= '0;
      state <= SETTLE;
      settle_cnt <= SETTLE_LOAD;
      half_cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      sel <= sync[SYNC_STAGES-1];
      state <= state_nx;
      settle_cnt <= settle_nx;
      half_cnt <= half_nx;
    end
  end
  // A zero half-period parks in SETTLE with the counter at 0 so it is re-sampled every cycle.
  always_comb begin
    state_nx = state;
    settle_nx = settle_cnt;
    half_nx = half_cnt;
    if (changed || powerdown) begin
      state_nx = SETTLE;
      settle_nx = SETTLE_LOAD;
    end else if (state == SETTLE) begin
      if (settle_cnt != '0) settle_nx = settle_cnt - 1'b1;
      else if (h != '0) begin
        state_nx = RUN_HIGH;
        half_nx = h - 1'b1;
      end
    end else if (half_cnt != '0) begin
      half_nx = half_cnt - 1'b1;
    end else if (h == '0) begin
      state_nx = SETTLE;
      settle_nx = '0;
    end else begin
      state_nx = state == RUN_HIGH ? RUN_LOW : RUN_HIGH;
      half_nx = h - 1'b1;
    end
  end
endmodule

// File: tb/tb_tcs_pulse_emulator.sv
// tb_tcs_pulse_emulator: directed and randomized checks of tcs_pulse_emulator against a timestamp-based reference model.
module tb_tcs_pulse_emulator;
  localparam int PW = 16, SC = 8, SS = 2;
  logic clk = 0, rst = 1, s2 = 0, s3 = 0;
  logic [PW-1:0] red_half = 5, blue_half = 4, clear_half = 0, green_half = 3;
  logic pulse, active;
  int checks = 0, failures = 0, cnt;
  tcs_pulse_emulator #(.PERIOD_W(PW), .SETTLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .s2(s2), .s3(s3),
    .red_half(red_half), .blue_half(blue_half), .clear_half(clear_half), .green_half(green_half),
    .pulse(pulse), .active(active)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  // Model: next decision instant kept as an absolute cycle number; select seen SS cycles late.
  logic [1:0] hist[SS];
  logic [1:0] m_sel;
  logic m_pulse, m_active;
  logic [PW-1:0] m_h;
  longint n, boundary;
  function automatic logic [PW-1:0] half_of(input logic [1:0] c);
    return c == 2'd0 ? red_half : c == 2'd1 ? blue_half : c == 2'd2 ? clear_half : green_half;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; boundary = SC; m_sel = 0; m_pulse = 0; m_active = 0;
      for (int i = 0; i < SS; i++) hist[i] = 0;
    end else begin
      n++;
      if (hist[SS-1] != m_sel) begin
        m_sel = hist[SS-1]; m_pulse = 0; m_active = 0; boundary = n + SC;
      end else if (n == boundary) begin
        m_h = half_of(m_sel);
        if (m_h == 0) begin
          m_pulse = 0; m_active = 0; boundary = n + 1;
        end else begin
          m_pulse = m_active ? !m_pulse : 1'b1; m_active = 1; boundary = n + m_h;
        end
      end
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {s2, s3};
    end
  end
  always @(negedge clk) if (!rst) begin
    check("pulse", pulse, m_pulse);
    check("active", active, m_active);
  end
  task automatic wait_level(input logic v);
    int c = 0;
    while (pulse !== v && c < 200) begin @(negedge clk); c++; end
    check("wait_level", pulse, v);
  endtask
  task automatic first_rise(input string tag);
    int c = 0;
    while (pulse !== 1'b1 && c < 60) begin @(negedge clk); c++; end
    check(tag, c, SC);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_pulse", pulse, 0);
    check("rst_active", active, 0);
    rst = 0;
    first_rise("first_rise");
    check("first_active", active, 1);
    repeat (30) @(negedge clk);
    wait_level(0); wait_level(1);
    green_half = 3; s2 = 1; s3 = 1;
    cnt = 0;
    while (pulse && cnt < 50) begin @(negedge clk); cnt++; end
    check("abort_fall", cnt, SS + 1);
    repeat (30) @(negedge clk);
    blue_half = 4; s2 = 0; s3 = 1;
    wait_level(0); wait_level(1);
    repeat (2) @(negedge clk);
    blue_half = 7;
    repeat (40) @(negedge clk);
    clear_half = 0; s2 = 1; s3 = 0;
    repeat (40) @(negedge clk);
    check("dark_pulse", pulse, 0);
    check("dark_active", active, 0);
    clear_half = 2;
    repeat (20) @(negedge clk);
    green_half = '1; s3 = 1;
    repeat (100) @(negedge clk);
    check("max_high", pulse, 1);
    red_half = 5; s2 = 0; s3 = 0;
    wait_level(0); wait_level(1);
    #2 rst = 1;
    #1 check("async_pulse", pulse, 0);
    check("async_active", active, 0);
    @(negedge clk) rst = 0;
    first_rise("rerise");
    for (int k = 0; k < 60; k++) begin
      red_half = PW'($urandom_range(0, 6));
      blue_half = PW'($urandom_range(1, 6));
      clear_half = PW'($urandom_range(0, 4));
      green_half = PW'($urandom_range(1, 9));
      if ($urandom_range(0, 3) != 0) {s2, s3} = 2'($urandom);
      repeat ($urandom_range(3, 40)) @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1;
        @(negedge clk) rst = 0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
